hc595_shift_out: RTL and testbench
==================================

# hc595_shift_out

- Serial back-end for the multiplexed seven-segment display path.
- Consumes the parallel `seg`/`sel` pair produced by the dynamic scan driver.
- Serialises it into two cascaded 74HC595 shift registers over the `ds`/`shcp`/`stcp`/`oe` pins.
- Transmits a new 14-bit frame only when the input pair changes, so a stable display causes no pin activity.
- Sits between the scan driver and the board pins in the seg_595 top level.

## Interface
- `CLK_DIV`, default 2: `sys_clk` cycles per `shcp` half-period. Legal range is ≥1.
- `REFRESH_CYC`, default 24'd4_999_999: period, in `sys_clk` cycles, of the forced re-send. Used only with `HC595_REFRESH_EN`.
- `sys_clk` input, 1 bit: clock.
- `sys_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `seg` input, 8 bits: segment pattern, active-low, bit 7 = dp.
- `sel` input, 6 bits: digit select, one-hot.
- `ds` output, 1 bit: serial data to the first 74HC595.
- `shcp` output, 1 bit: shift clock. Data is sampled by the 74HC595 on the rising edge.
- `stcp` output, 1 bit: storage (latch) clock. The latch takes effect on the rising edge.
- `oe` output, 1 bit: output enable, active-low.

## Operation
- Frame definition: `frame[13:0] = {seg[7:0], sel[5:0]}`.
- Shift order is LSB first: `sel[0]` is shifted first and `seg[7]` last, giving 14 bits.
- State machine: IDLE → LOAD → SHIFT → LATCH → IDLE.
- IDLE:
  - `shcp`=0, `stcp`=0, `ds` holds its last value.
  - Go to LOAD when `{seg,sel} != shadow` or `pending`=1.
- LOAD, 1 cycle:
  - `snap <= {seg,sel}`, `shadow <= {seg,sel}`.
  - Clear `pending`, `bit_cnt <= 0`, `div_cnt <= 0`.
- SHIFT:
  - Each bit lasts `2*CLK_DIV` cycles.
  - Low phase (CLK_DIV cycles): `shcp`=0, and `ds = snap[bit_cnt]`, which is updated on the first low cycle.
  - High phase (CLK_DIV cycles): `shcp`=1.
  - At the end of the high phase for `bit_cnt`=13, go to LATCH. Otherwise increment `bit_cnt`.
- LATCH:
  - `stcp`=1 for CLK_DIV cycles, then IDLE with `stcp`=0.
  - Set the `oe_armed` flag on exit.
- `oe` = ~`oe_armed`. The display stays dark until the first complete frame is latched, then `oe`=0 permanently.
- `pending` is set by reset. This forces the first frame after reset even if the inputs equal the reset shadow.
- Input changes during LOAD+1…LATCH do not affect the frame in flight, which uses `snap`. They are compared against `shadow` in the next IDLE cycle, and another frame follows.
- Reset mid-operation: all state returns to reset values immediately and a partial frame is abandoned. `stcp` is never pulsed for a partial frame.

## Timing
- Reset values:
  - Outputs: `ds`=0, `shcp`=0, `stcp`=0, `oe`=1.
  - Internal: state=IDLE, `shadow`=14'h0000, `snap`=0, `pending`=1, `oe_armed`=0.
- All outputs are registered. No combinational path from inputs to pins.
- Frame length, from the IDLE cycle that detects a change to the next IDLE: `1 + 28*CLK_DIV + CLK_DIV` cycles. This is 59 cycles at CLK_DIV=2.
- First `shcp` rise comes CLK_DIV+1 cycles after LOAD.
- `ds` is stable CLK_DIV cycles before and CLK_DIV cycles after each `shcp` rise.
- `stcp` rises CLK_DIV cycles after the last `shcp` rise. That rise coincides with `shcp` returning to 0.
- Back-to-back frames have a minimum of 1 IDLE cycle between them.
- A 1 ms scan step at 50 MHz leaves ample margin.

## Configuration
- `HC595_REFRESH_EN` defined:
  - A free-running counter `0…REFRESH_CYC-1` sets `pending` on wrap.
  - A wrap during a frame leaves `pending` set, so the re-send follows that frame.
  - A wrap and an input change in the same cycle produce one frame only.
  - This recovers the 74HC595s from pin glitches.
- Not defined:
  - The counter is absent.
  - `pending` is set only by reset.
  - Frames are sent on change only.

## Test plan
- Reset: hold `sys_rst_n`=0 → `ds`=0, `shcp`=0, `stcp`=0, `oe`=1. Release with `seg`=8'hFF, `sel`=6'h00:
  - One frame of 59 cycles, 14 `shcp` rises, sampled bits 0,0,0,0,0,0,1,1,1,1,1,1,1,1.
  - One `stcp` pulse, then `oe`=0.
- Change `sel`→6'b000001 and `seg`→8'hC0 → frame bits 1,0,0,0,0,0,0,0,0,0,0,0,1,1 (sel[0]…seg[7]) and latch. With stable inputs, no `shcp` edge occurs for 1000 cycles (macro off).
- Change `seg` at bit 5 of a frame → the current frame completes with the old value, then exactly one extra frame carries the new value.
- Assert reset during bit 7 → outputs return to reset values in the same cycle, and no `stcp` pulse occurs. After release, a full frame is sent.
- `HC595_REFRESH_EN` with `REFRESH_CYC`=200 and stable inputs → one frame every 200 cycles carrying identical bits.
- `HC595_REFRESH_EN` with a wrap coinciding with an input change → exactly one frame.
- CLK_DIV=1 → frame length is 30 cycles, and `shcp` high and low phases last 1 cycle each.

Source files
------------

// File: rtl/hc595_shift_out.sv
// Serialises the {seg,sel} pair into two cascaded 74HC595s, sending a 14-bit frame LSB first only on change.
// Define HC595_REFRESH_EN to also force a periodic re-send every REFRESH_CYC cycles.
module hc595_shift_out #(
    parameter int unsigned CLK_DIV     = 2,
    parameter logic [23:0] REFRESH_CYC = 24'd4_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] seg,
    input  logic [5:0] sel,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe
);

    localparam int unsigned      DIV_W    = $clog2(2 * CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LAT_END  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'd13;

    if (CLK_DIV == 0 || REFRESH_CYC == 24'd0) begin : g_bad_cfg
        $error("hc595_shift_out: CLK_DIV and REFRESH_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [13:0]      r_snap,     w_snap_nxt;
    logic [13:0]      r_shadow,   w_shadow_nxt;
    logic             r_pending,  w_pending_nxt;
    logic             r_oe,       w_oe_nxt;
    logic [3:0]       r_bit_cnt,  w_bit_nxt;
    logic [DIV_W-1:0] r_div_cnt,  w_div_nxt;
    logic             r_ds,       w_ds_nxt;
    logic             r_shcp,     w_shcp_nxt;
    logic             r_stcp,     w_stcp_nxt;
    logic [13:0]      w_frame;
    logic             w_ref_wrap;

    assign w_frame = {seg, sel};

`ifdef HC595_REFRESH_EN
    logic [23:0] r_ref_cnt;

    assign w_ref_wrap = (r_ref_cnt == REFRESH_CYC - 24'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)      r_ref_cnt <= '0;
        else if (w_ref_wrap) r_ref_cnt <= '0;
        else                 r_ref_cnt <= r_ref_cnt + 24'd1;
    end
`else
    assign w_ref_wrap = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b1;
            r_oe      <= 1'b1;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_ds      <= 1'b0;
            r_shcp    <= 1'b0;
            r_stcp    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_snap    <= w_snap_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_oe      <= w_oe_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_div_cnt <= w_div_nxt;
            r_ds      <= w_ds_nxt;
            r_shcp    <= w_shcp_nxt;
            r_stcp    <= w_stcp_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_snap_nxt    = r_snap;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_oe_nxt      = r_oe;
        w_bit_nxt     = r_bit_cnt;
        w_div_nxt     = r_div_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if ((w_frame != r_shadow) || r_pending) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_snap_nxt    = w_frame;
                w_shadow_nxt  = w_frame;
                w_pending_nxt = 1'b0;
                w_bit_nxt     = '0;
                w_div_nxt     = '0;
                w_state_nxt   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_div_cnt == DIV_END) begin
                    w_div_nxt = '0;
                    if (r_bit_cnt == LAST_BIT) w_state_nxt = ST_LATCH;
                    else                       w_bit_nxt   = r_bit_cnt + 4'd1;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            ST_LATCH: begin
                if (r_div_cnt == LAT_END) begin
                    w_div_nxt   = '0;
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A refresh wrap wins over the LOAD clear so a wrap inside a frame queues a re-send.
        if (w_ref_wrap) w_pending_nxt = 1'b1;

        // Pin values are derived from the next state so every pin leaves a flop.
        w_shcp_nxt = (w_state_nxt == ST_SHIFT) && (w_div_nxt >= DIV_HI);
        w_stcp_nxt = (w_state_nxt == ST_LATCH);
        w_ds_nxt   = ((w_state_nxt == ST_SHIFT) && (w_div_nxt == '0)) ? w_snap_nxt[w_bit_nxt] : r_ds;
    end

    assign ds   = r_ds;
    assign shcp = r_shcp;
    assign stcp = r_stcp;
    assign oe   = r_oe;

endmodule

// File: tb/tb_hc595_shift_out.sv
// Directed bench for hc595_shift_out: one CLK_DIV=2 instance and one CLK_DIV=1 instance.
// Pin activity is reconstructed into 74HC595-style frames by a negedge monitor.
module tb_hc595_shift_out;

    typedef struct {
        logic [13:0] word;
        int          nbits;
        int          span;
        int          wst;
        int          hi;
        int          endc;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg0, seg1;
    logic [5:0] sel0, sel1;
    logic       ds0, shcp0, stcp0, oe0;
    logic       ds1, shcp1, stcp1, oe1;
    logic [1:0] ds_v, shcp_v, stcp_v;

    frame_t      q0[$];
    frame_t      f1;
    int          cyc;
    int          nrise[2], first_hi[2], last_st[2], wst[2], hi_cnt[2];
    int          nfr[2], nlatch[2], tot_rise[2], ds_glitch[2];
    logic [13:0] word[2];
    logic        shcp_q[2], stcp_q[2], ds_at_rise[2];
    int          n_vec, n_miss;

    hc595_shift_out #(.CLK_DIV(2), .REFRESH_CYC(24'd200)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .seg(seg0), .sel(sel0),
        .ds(ds0), .shcp(shcp0), .stcp(stcp0), .oe(oe0)
    );

    hc595_shift_out #(.CLK_DIV(1), .REFRESH_CYC(24'd200)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .seg(seg1), .sel(sel1),
        .ds(ds1), .shcp(shcp1), .stcp(stcp1), .oe(oe1)
    );

    assign ds_v   = {ds1, ds0};
    assign shcp_v = {shcp1, shcp0};
    assign stcp_v = {stcp1, stcp0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        frame_t f;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                nrise[i] = 0; word[i] = '0; wst[i] = 0; hi_cnt[i] = 0;
            end else begin
                if (shcp_v[i] && !shcp_q[i]) begin
                    if (nrise[i] == 0) first_hi[i] = cyc;
                    if (nrise[i] < 14) word[i][nrise[i]] = ds_v[i];
                    ds_at_rise[i] = ds_v[i];
                    nrise[i]++;
                    tot_rise[i]++;
                end else if (shcp_v[i] && (ds_v[i] !== ds_at_rise[i])) begin
                    ds_glitch[i]++;
                end
                if (shcp_v[i]) hi_cnt[i]++;
                if (stcp_v[i]) begin
                    wst[i]++;
                    last_st[i] = cyc;
                end
                if (stcp_v[i] && !stcp_q[i]) nlatch[i]++;
                if (!stcp_v[i] && stcp_q[i]) begin
                    f.word  = word[i];
                    f.nbits = nrise[i];
                    f.span  = last_st[i] - first_hi[i] + 1;
                    f.wst   = wst[i];
                    f.hi    = hi_cnt[i];
                    f.endc  = cyc;
                    if (i == 0) q0.push_back(f);
                    else        f1 = f;
                    nfr[i]++;
                    nrise[i] = 0; word[i] = '0; wst[i] = 0; hi_cnt[i] = 0;
                end
            end
            shcp_q[i] = shcp_v[i];
            stcp_q[i] = stcp_v[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int inst, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (nfr[inst] < n && k < budget) begin
            tick(1);
            k++;
        end
        check_val(tag, nfr[inst], n);
    endtask

    task automatic wait_rise(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (nrise[0] < n && k < budget) begin
            tick(1);
            k++;
        end
        check_val(tag, nrise[0], n);
    endtask

    function automatic frame_t get0(input int idx);
        frame_t z;
        z = '{default: 0};
        if (idx >= 0 && idx < q0.size()) z = q0[idx];
        return z;
    endfunction

    initial begin
        frame_t fr;
        int     base, r, l;
        rst_n = 1'b0;
        seg0  = 8'hFF; sel0 = 6'h00;
        seg1  = 8'h81; sel1 = 6'h20;
        tick(3);
        check_val("rst_ds",   ds0,   1'b0);
        check_val("rst_shcp", shcp0, 1'b0);
        check_val("rst_stcp", stcp0, 1'b0);
        check_val("rst_oe",   oe0,   1'b1);

        // First frame is forced by pending even though nothing "changed".
        rst_n = 1'b1;
        wait_frames(0, 1, 200, "f0_done");
        fr = get0(0);
        check_val("f0_word",   fr.word,  14'h3FC0);
        check_val("f0_nbits",  fr.nbits, 14);
        check_val("f0_span",   fr.span,  56);
        check_val("f0_stcp_w", fr.wst,   2);
        check_val("f0_shcp_h", fr.hi,    28);
        check_val("f0_oe",     oe0,      1'b0);
        check_val("f0_latch",  nlatch[0], 1);

        wait_frames(1, 1, 100, "d1_done");
        check_val("d1_word",   f1.word,  14'h2060);
        check_val("d1_nbits",  f1.nbits, 14);
        check_val("d1_span",   f1.span,  28);
        check_val("d1_stcp_w", f1.wst,   1);
        check_val("d1_shcp_h", f1.hi,    14);
        check_val("d1_oe",     oe1,      1'b0);

        tick(50);
`ifndef HC595_REFRESH_EN
        check_val("no_resend", nfr[0], 1);
`endif

        seg0 = 8'hC0; sel0 = 6'b000001;
        wait_frames(0, 2, 200, "fc0_done");
        fr = get0(1);
        check_val("fc0_word",  fr.word,  14'h3001);
        check_val("fc0_nbits", fr.nbits, 14);
`ifndef HC595_REFRESH_EN
        r = tot_rise[0];
        l = nlatch[0];
        tick(1000);
        check_val("quiet_shcp", tot_rise[0], r);
        check_val("quiet_stcp", nlatch[0],   l);
`endif

        // Input change while bit 5 is in flight.
        base = nfr[0];
        seg0 = 8'hA4;
        wait_rise(5, 100, "mid_bit5");
        seg0 = 8'h99;
        wait_frames(0, base + 2, 300, "two_frames");
        fr = get0(base);
        check_val("old_word", fr.word, 14'h2901);
        fr = get0(base + 1);
        check_val("new_word", fr.word, 14'h2641);
`ifndef HC595_REFRESH_EN
        tick(100);
        check_val("no_third", nfr[0], base + 2);
`endif

        // Reset while bit 7 (a 1) is being clocked out.
        base = nfr[0];
        l    = nlatch[0];
        seg0 = 8'h5A;
        wait_rise(8, 100, "mid_bit7");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst2_ds",   ds0,   1'b0);
        check_val("rst2_shcp", shcp0, 1'b0);
        check_val("rst2_stcp", stcp0, 1'b0);
        check_val("rst2_oe",   oe0,   1'b1);
        tick(3);
        check_val("no_part_latch", nlatch[0], l);
        check_val("no_part_frame", nfr[0],    base);
        rst_n = 1'b1;
        wait_frames(0, base + 1, 200, "post_rst");
        fr = get0(base);
        check_val("post_rst_word", fr.word, 14'h1681);
        check_val("post_rst_oe",   oe0,     1'b0);

`ifdef HC595_REFRESH_EN
        base = nfr[0];
        wait_frames(0, base + 1, 300, "ref_first");
        base = nfr[0];
        tick(1000);
        check_val("ref_count", nfr[0], base + 5);
        fr = get0(q0.size() - 1);
        check_val("ref_word", fr.word, 14'h1681);
        check_val("ref_period", get0(q0.size() - 1).endc - get0(q0.size() - 2).endc, 200);
        // Now at a refresh frame end; the next wrap is 139 cycles away.
        tick(140);
        base = nfr[0];
        seg0 = 8'h3C;
        tick(150);
        check_val("ref_coincide_one", nfr[0], base + 1);
        fr = get0(q0.size() - 1);
        check_val("ref_coincide_word", fr.word, 14'h0F01);
`endif

        check_val("ds_stable0", ds_glitch[0], 0);
        check_val("ds_stable1", ds_glitch[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
